// File: rtl/alu_bist.sv
// Built-in self test for a 32-bit, 8-operation ALU.
// An LFSR generates the operands, the opcode cycles through all eight operations,
// and each ALU response is compared against an internal golden model.
// Each vector takes two cycles: DRIVE registers the operands, and CHECK compares
// the returned result after one full cycle of combinational settle time.
// Handshake: START is a level sampled on the rising edge in IDLE or FIN only.
// While BUSY is high, START is ignored. When DONE is high, PASS, ERR_CNT and
// FAIL_* are valid, and they hold until the next START or reset.
module alu_bist #(
    parameter int          N_VEC = 64,
    parameter logic [31:0] SEED  = 32'hACE1_2024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [31:0] ALU_RSLT,
    input  logic        ALU_ZR,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [2:0]  ALU_OPC,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERR_CNT,
    output logic        FAIL_VLD,
    output logic [7:0]  FAIL_IDX,
    output logic [1:0]  STATE_DBG
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CHECK = 2'd2, FIN = 2'd3} state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [7:0]  LAST_IDX  = 8'(N_VEC - 1);

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_opc_q, alu_opc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        fail_vld_q, fail_vld_d;
    logic [7:0]  fail_idx_q, fail_idx_d;

    logic [31:0] gold_rslt;
    logic        gold_zr;
    logic        mismatch;
    logic [31:0] lfsr_next;
    logic [7:0]  idx_next;

    // Golden model of the ALU, evaluated on the registered operands
    always_comb begin
        gold_rslt = 32'd0;
        case (alu_opc_q)
            3'b000:  gold_rslt = alu_a_q + alu_b_q;
            3'b001:  gold_rslt = alu_a_q - alu_b_q;
            3'b010:  gold_rslt = alu_a_q & alu_b_q;
            3'b011:  gold_rslt = alu_a_q | alu_b_q;
            3'b100:  gold_rslt = alu_a_q ^ alu_b_q;
            3'b101:  gold_rslt = {31'd0, ($signed(alu_a_q) < $signed(alu_b_q))};
            3'b110:  gold_rslt = alu_a_q << alu_b_q[4:0];
            default: gold_rslt = alu_a_q >> alu_b_q[4:0];
        endcase
        gold_zr  = (gold_rslt == 32'd0);
        mismatch = (ALU_RSLT != gold_rslt) || (ALU_ZR != gold_zr);
    end

    // One LFSR step and the incremented index, used when moving to the next vector
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
        idx_next  = idx_q + 8'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_opc_d  = alu_opc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vld_d = fail_vld_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d    = DRIVE;
                    lfsr_d     = SEED;
                    idx_d      = 8'd0;
                    alu_a_d    = SEED;
                    alu_b_d    = {SEED[15:0], SEED[31:16]};
                    alu_opc_d  = 3'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_cnt_d  = 8'd0;
                    fail_vld_d = 1'b0;
                    fail_idx_d = 8'd0;
                end
            end
            DRIVE: begin
                // Operands stay put so the ALU has a full cycle to settle
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_idx_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 8'd0);
                end else begin
                    state_d   = DRIVE;
                    idx_d     = idx_next;
                    lfsr_d    = lfsr_next;
                    alu_a_d   = lfsr_next;
                    alu_b_d   = {lfsr_next[15:0], lfsr_next[31:16]};
                    alu_opc_d = idx_next[2:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any run in progress
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            idx_q      <= 8'd0;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_opc_q  <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
            fail_vld_q <= 1'b0;
            fail_idx_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_opc_q  <= alu_opc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vld_q <= fail_vld_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_OPC   = alu_opc_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_cnt_q;
    assign FAIL_VLD  = fail_vld_q;
    assign FAIL_IDX  = fail_idx_q;
    assign STATE_DBG = state_q;

endmodule
